// File: rtl/wb_master_if_pkg.sv
// ---------------------------------------------------------------------------
// wb_master_if_pkg
// Shared definitions for the Wishbone classic master bridge:
//   - FSM state encoding (IDLE / BUSY / WAIT_STALL)
//   - pipeline stall vector width
//   - default bus widths and an all-zero data word
// ---------------------------------------------------------------------------
package wb_master_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_BUSY       = 2'b01,
    ST_WAIT_STALL = 2'b10
  } wb_state_e;

  localparam int STALL_W = 6;
  localparam int WB_AW   = 32;
  localparam int WB_DW   = 32;

  localparam logic [WB_DW-1:0] ZERO_WORD = 32'h0000_0000;

endpackage : wb_master_if_pkg

// File: rtl/wb_timeout_cnt.sv
// ---------------------------------------------------------------------------
// wb_timeout_cnt
// Counts BUSY cycles that pass without an acknowledge and raises term_o once
// the count reaches TIMEOUT_CYCLES-1. Only built when WB_TIMEOUT_EN is set.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   clr_i   hold the count at zero (asserted whenever the master is not BUSY)
//   inc_i   advance the count by one (a BUSY cycle with no ack)
//   term_o  count has reached TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module wb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_o
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign term_o = (cnt_q == TERM);

  // Next count: clear outside BUSY, saturate at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !term_o) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : wb_timeout_cnt

// File: rtl/wb_master_if.sv
// ---------------------------------------------------------------------------
// wb_master_if
// Wishbone B.3 classic single-cycle master that turns a level-held CPU memory
// request into one Wishbone cycle, stalls the pipeline until the slave acks,
// and holds the read data while the pipeline stays frozen for other reasons.
//
// Optional build macro: WB_TIMEOUT_EN -- aborts a BUSY cycle after
// TIMEOUT_CYCLES cycles without ack and pulses wb_err_o.
//
// Ports:
//   wb_clk_i / wb_rst_i    clock, asynchronous active-low reset
//   stall_i, flush_i       pipeline stall vector and flush
//   cpu_ce_i .. cpu_sel_i  CPU request (held until taken)
//   cpu_data_o             read data back to the CPU
//   stallreq_o             stall request to the pipeline controller
//   wb_*                   Wishbone master signals
//   wb_err_o               timeout abort pulse (WB_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module wb_master_if
  import wb_master_if_pkg::*;
#(
  parameter int AW             = WB_AW,
  parameter int DW             = WB_DW,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic               cpu_ce_i,
  input  logic [AW-1:0]      cpu_addr_i,
  input  logic [DW-1:0]      cpu_data_i,
  input  logic               cpu_we_i,
  input  logic [DW/8-1:0]    cpu_sel_i,
  output logic [DW-1:0]      cpu_data_o,
  output logic               stallreq_o,
  output logic [AW-1:0]      wb_adr_o,
  output logic [DW-1:0]      wb_dat_o,
  input  logic [DW-1:0]      wb_dat_i,
  output logic               wb_we_o,
  output logic [DW/8-1:0]    wb_sel_o,
  output logic               wb_stb_o,
  output logic               wb_cyc_o,
  input  logic               wb_ack_i
`ifdef WB_TIMEOUT_EN
  ,
  output logic               wb_err_o
`endif
);

  wb_state_e state_q;
  wb_state_e state_d;

  logic [AW-1:0]   adr_q,    adr_d;
  logic [DW-1:0]   dat_q,    dat_d;
  logic            we_q,     we_d;
  logic [DW/8-1:0] sel_q,    sel_d;
  logic            cyc_q,    cyc_d;
  logic            stb_q,    stb_d;
  logic [DW-1:0]   rd_buf_q, rd_buf_d;

  logic stall_any_s;
  logic launch_s;
  logic busy_s;
  logic busy_end_s;
  logic tmo_hit_s;
  logic err_s;

  assign stall_any_s = |stall_i;
  assign busy_s      = (state_q == ST_BUSY);
  assign launch_s    = (state_q == ST_IDLE) && cpu_ce_i && !flush_i;
  // Any of flush, ack or timeout terminates the bus cycle.
  assign busy_end_s  = busy_s && (flush_i || wb_ack_i || tmo_hit_s);

`ifdef WB_TIMEOUT_EN
  logic tmo_term_s;

  wb_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_i),
    .clr_i  (!busy_s),
    .inc_i  (busy_s && !wb_ack_i && !flush_i),
    .term_o (tmo_term_s)
  );

  assign tmo_hit_s = busy_s && tmo_term_s;
  assign wb_err_o  = err_s;
`else
  assign tmo_hit_s = 1'b0;

  // TIMEOUT_CYCLES only matters when the timeout logic is built in.
  if (TIMEOUT_CYCLES < 2) begin : g_tmo_cfg_unused
  end
`endif

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush outranks ack, ack outranks timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (launch_s) state_d = ST_BUSY;
        else          state_d = ST_IDLE;
      end
      ST_BUSY: begin
        if (flush_i)                       state_d = ST_IDLE;
        else if (wb_ack_i && stall_any_s)  state_d = ST_WAIT_STALL;
        else if (wb_ack_i || tmo_hit_s)    state_d = ST_IDLE;
        else                               state_d = ST_BUSY;
      end
      ST_WAIT_STALL: begin
        if (flush_i || !stall_any_s) state_d = ST_IDLE;
        else                         state_d = ST_WAIT_STALL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs to the CPU side: stall request, returned data, timeout flag.
  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    err_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stallreq_o = cpu_ce_i & ~flush_i;
      end
      ST_BUSY: begin
        stallreq_o = ~wb_ack_i & ~tmo_hit_s;
        if (flush_i) begin
          cpu_data_o = '0;
        end else if (wb_ack_i) begin
          cpu_data_o = we_q ? '0 : wb_dat_i;
        end else if (tmo_hit_s) begin
          cpu_data_o = '1;
          err_s      = 1'b1;
        end else begin
          cpu_data_o = '0;
        end
      end
      ST_WAIT_STALL: begin
        cpu_data_o = rd_buf_q;
      end
      default: begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
      end
    endcase
  end

  // Wishbone request fields and read buffer: latch on launch, clear on end.
  always_comb begin
    adr_d    = adr_q;
    dat_d    = dat_q;
    we_d     = we_q;
    sel_d    = sel_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    rd_buf_d = rd_buf_q;
    if (launch_s) begin
      adr_d = cpu_addr_i;
      dat_d = cpu_data_i;
      we_d  = cpu_we_i;
      sel_d = cpu_sel_i;
      cyc_d = 1'b1;
      stb_d = 1'b1;
    end else if (busy_end_s) begin
      adr_d = '0;
      dat_d = '0;
      we_d  = 1'b0;
      sel_d = '0;
      cyc_d = 1'b0;
      stb_d = 1'b0;
    end else begin
      cyc_d = cyc_q;
    end
    // A write completion loads zero so a following WAIT_STALL returns 0.
    if (busy_s && wb_ack_i && !flush_i) begin
      rd_buf_d = we_q ? '0 : wb_dat_i;
    end else begin
      rd_buf_d = rd_buf_q;
    end
  end

  // Registered Wishbone outputs and read buffer; reset aborts the cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      adr_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      rd_buf_q <= '0;
    end else begin
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      rd_buf_q <= rd_buf_d;
    end
  end

  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_we_o  = we_q;
  assign wb_sel_o = sel_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;

endmodule : wb_master_if

// File: tb/tb_wb_master_if.sv
// ---------------------------------------------------------------------------
// tb_wb_master_if
// Directed bench for wb_master_if: the Wishbone slave is modelled by driving
// wb_ack_i / wb_dat_i by hand, cycle by cycle. Inputs change 1 ns after the
// rising edge, outputs are checked 2 ns after it.
// ---------------------------------------------------------------------------
module tb_wb_master_if;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic [5:0]    stall_i;
  logic          flush_i;
  logic          cpu_ce_i;
  logic [AW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_data_i;
  logic          cpu_we_i;
  logic [3:0]    cpu_sel_i;
  logic [DW-1:0] cpu_data_o;
  logic          stallreq_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_we_o;
  logic [3:0]    wb_sel_o;
  logic          wb_stb_o;
  logic          wb_cyc_o;
  logic          wb_ack_i;
`ifdef WB_TIMEOUT_EN
  logic          wb_err_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  wb_master_if #(
    .AW             (AW),
    .DW             (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_i (cpu_data_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_data_o (cpu_data_o),
    .stallreq_o (stallreq_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_ack_i   (wb_ack_i)
`ifdef WB_TIMEOUT_EN
    ,
    .wb_err_o   (wb_err_o)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_rst_i = 1'b0; stall_i = 6'd0; flush_i = 1'b0; cpu_ce_i = 1'b0;
    cpu_addr_i = 32'h0; cpu_data_i = 32'h0; cpu_we_i = 1'b0; cpu_sel_i = 4'h0;
    wb_dat_i = 32'h0; wb_ack_i = 1'b0;

    // ---- reset state ----
    tick(); tick(); #1;
    chk("rst_cyc", wb_cyc_o, 32'd0);
    chk("rst_stb", wb_stb_o, 32'd0);
    chk("rst_we", wb_we_o, 32'd0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_sel", wb_sel_o, 32'h0);
    chk("rst_cpu_data", cpu_data_o, 32'h0);
    chk("rst_stallreq", stallreq_o, 32'd0);
    tick(); wb_rst_i = 1'b1;

    // ---- read, registered ack ----
    tick(); cpu_ce_i = 1'b1; cpu_addr_i = 32'h100; cpu_we_i = 1'b0; cpu_sel_i = 4'hF; #1;
    chk("rd_idle_stallreq", stallreq_o, 32'd1);
    chk("rd_idle_cyc", wb_cyc_o, 32'd0);
    tick(); #1;
    chk("rd_busy_cyc", wb_cyc_o, 32'd1);
    chk("rd_busy_stb", wb_stb_o, 32'd1);
    chk("rd_busy_adr", wb_adr_o, 32'h100);
    chk("rd_busy_we", wb_we_o, 32'd0);
    chk("rd_busy_sel", wb_sel_o, 32'hF);
    chk("rd_busy_stallreq", stallreq_o, 32'd1);
    chk("rd_busy_data", cpu_data_o, 32'h0);
    tick(); wb_ack_i = 1'b1; wb_dat_i = 32'hDEADBEEF; #1;
    chk("rd_ack_data", cpu_data_o, 32'hDEADBEEF);
    chk("rd_ack_stallreq", stallreq_o, 32'd0);
    chk("rd_ack_stb", wb_stb_o, 32'd1);
    tick(); wb_ack_i = 1'b0; wb_dat_i = 32'h0; cpu_ce_i = 1'b0; #1;
    chk("rd_done_cyc", wb_cyc_o, 32'd0);
    chk("rd_done_stb", wb_stb_o, 32'd0);
    chk("rd_done_adr", wb_adr_o, 32'h0);
    chk("rd_done_stallreq", stallreq_o, 32'd0);
    chk("rd_done_data", cpu_data_o, 32'h0);

    // ---- write, CPU inputs change while BUSY ----
    tick(); cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h10;
    cpu_data_i = 32'h12345678; cpu_sel_i = 4'b0011; #1;
    chk("wr_idle_stallreq", stallreq_o, 32'd1);
    tick(); cpu_addr_i = 32'h999; cpu_data_i = 32'hFFFF0000; cpu_sel_i = 4'hC; cpu_we_i = 1'b0; #1;
    chk("wr_busy_adr", wb_adr_o, 32'h10);
    chk("wr_busy_dat", wb_dat_o, 32'h12345678);
    chk("wr_busy_sel", wb_sel_o, 32'h3);
    chk("wr_busy_we", wb_we_o, 32'd1);
    chk("wr_busy_cyc", wb_cyc_o, 32'd1);
    tick(); #1;
    chk("wr_hold_adr", wb_adr_o, 32'h10);
    chk("wr_hold_dat", wb_dat_o, 32'h12345678);
    chk("wr_hold_sel", wb_sel_o, 32'h3);
    chk("wr_hold_we", wb_we_o, 32'd1);
    chk("wr_hold_stallreq", stallreq_o, 32'd1);
    tick(); wb_ack_i = 1'b1; wb_dat_i = 32'hAAAAAAAA; cpu_ce_i = 1'b0; #1;
    chk("wr_ack_data", cpu_data_o, 32'h0);
    chk("wr_ack_stallreq", stallreq_o, 32'd0);
    tick(); wb_ack_i = 1'b0; wb_dat_i = 32'h0; #1;
    chk("wr_done_we", wb_we_o, 32'd0);
    chk("wr_done_cyc", wb_cyc_o, 32'd0);
    chk("wr_done_adr", wb_adr_o, 32'h0);
    chk("wr_done_dat", wb_dat_o, 32'h0);
    chk("wr_done_sel", wb_sel_o, 32'h0);

    // ---- read acked while pipeline stalled (combinational ack) ----
    tick(); cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h200; cpu_sel_i = 4'hF; #1;
    chk("st_idle_stallreq", stallreq_o, 32'd1);
    tick(); wb_ack_i = 1'b1; wb_dat_i = 32'hCAFEF00D; stall_i = 6'b000011; #1;
    chk("st_ack_data", cpu_data_o, 32'hCAFEF00D);
    chk("st_ack_stallreq", stallreq_o, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); wb_ack_i = 1'b0; wb_dat_i = 32'h0; #1;
      chk("st_wait_data", cpu_data_o, 32'hCAFEF00D);
      chk("st_wait_stallreq", stallreq_o, 32'd0);
      chk("st_wait_cyc", wb_cyc_o, 32'd0);
    end
    tick(); stall_i = 6'd0; cpu_ce_i = 1'b0; #1;
    chk("st_release_data", cpu_data_o, 32'hCAFEF00D);
    // back in IDLE: a new request is seen immediately
    tick(); cpu_ce_i = 1'b1; cpu_addr_i = 32'h300; #1;
    chk("st_idle_again_stallreq", stallreq_o, 32'd1);
    chk("st_idle_again_data", cpu_data_o, 32'h0);

    // ---- flush during BUSY without ack ----
    tick(); flush_i = 1'b1; #1;
    chk("fl_busy_cyc", wb_cyc_o, 32'd1);
    chk("fl_busy_adr", wb_adr_o, 32'h300);
    chk("fl_busy_data", cpu_data_o, 32'h0);
    tick(); flush_i = 1'b0; cpu_ce_i = 1'b0; #1;
    chk("fl_done_cyc", wb_cyc_o, 32'd0);
    chk("fl_done_stb", wb_stb_o, 32'd0);
    chk("fl_done_adr", wb_adr_o, 32'h0);
    chk("fl_done_stallreq", stallreq_o, 32'd0);
    chk("fl_done_data", cpu_data_o, 32'h0);

    // ---- flush and ack together: flush wins ----
    tick(); cpu_ce_i = 1'b1; cpu_addr_i = 32'h400; #1;
    chk("fa_idle_stallreq", stallreq_o, 32'd1);
    tick(); flush_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'h11112222; stall_i = 6'b000011; #1;
    chk("fa_data", cpu_data_o, 32'h0);
    tick(); flush_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = 32'h0; stall_i = 6'd0; cpu_addr_i = 32'h500; #1;
    chk("fa_after_cyc", wb_cyc_o, 32'd0);
    chk("fa_after_stallreq", stallreq_o, 32'd1);
    chk("fa_after_data", cpu_data_o, 32'h0);

    // ---- completed read, lingering ack, back-to-back request ----
    tick(); #1;
    chk("ln_busy_stb", wb_stb_o, 32'd1);
    chk("ln_busy_adr", wb_adr_o, 32'h500);
    tick(); wb_ack_i = 1'b1; wb_dat_i = 32'h5555AAAA; cpu_addr_i = 32'h504; #1;
    chk("ln_ack_data", cpu_data_o, 32'h5555AAAA);
    chk("ln_ack_stallreq", stallreq_o, 32'd0);
    tick(); wb_dat_i = 32'h77777777; #1;
    chk("ln_linger_stb", wb_stb_o, 32'd0);
    chk("ln_linger_data", cpu_data_o, 32'h0);
    chk("ln_linger_stallreq", stallreq_o, 32'd1);
    tick(); wb_ack_i = 1'b0; wb_dat_i = 32'h0; #1;
    chk("ln_second_stb", wb_stb_o, 32'd1);
    chk("ln_second_adr", wb_adr_o, 32'h504);
    chk("ln_second_stallreq", stallreq_o, 32'd1);
    tick(); wb_ack_i = 1'b1; wb_dat_i = 32'h13579BDF; cpu_ce_i = 1'b0; #1;
    chk("ln_second_data", cpu_data_o, 32'h13579BDF);
    tick(); wb_ack_i = 1'b0; wb_dat_i = 32'h0; #1;
    chk("ln_second_done_cyc", wb_cyc_o, 32'd0);

    // ---- reset asserted mid-BUSY ----
    tick(); cpu_ce_i = 1'b1; cpu_addr_i = 32'h600; #1;
    tick(); #1;
    chk("ar_busy_cyc", wb_cyc_o, 32'd1);
    wb_rst_i = 1'b0; #1;
    chk("ar_async_cyc", wb_cyc_o, 32'd0);
    chk("ar_async_stb", wb_stb_o, 32'd0);
    chk("ar_async_adr", wb_adr_o, 32'h0);
    cpu_ce_i = 1'b0;
    tick(); wb_rst_i = 1'b1; #1;
    chk("ar_release_cyc", wb_cyc_o, 32'd0);
    chk("ar_release_stallreq", stallreq_o, 32'd0);

`ifdef WB_TIMEOUT_EN
    // ---- timeout abort after 16 BUSY cycles without ack ----
    tick(); cpu_ce_i = 1'b1; cpu_addr_i = 32'h700; #1;
    for (int k = 1; k <= 15; k++) begin
      tick(); #1;
      chk("to_wait_err", wb_err_o, 32'd0);
      chk("to_wait_stb", wb_stb_o, 32'd1);
    end
    tick(); #1;
    chk("to_hit_err", wb_err_o, 32'd1);
    chk("to_hit_data", cpu_data_o, 32'hFFFFFFFF);
    chk("to_hit_stallreq", stallreq_o, 32'd0);
    cpu_ce_i = 1'b0;
    tick(); #1;
    chk("to_after_cyc", wb_cyc_o, 32'd0);
    chk("to_after_err", wb_err_o, 32'd0);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_wb_master_if

// File: doc/wb_master_if.md
Name: wb_master_if

Overview:
- Wishbone B.3 classic single-cycle master that bridges a CPU pipeline memory port (instruction or data) onto the shared Wishbone bus.
- Converts a level-held CPU request into one Wishbone cycle and stalls the pipeline until the slave acks.
- Buffers the read data while the pipeline stays stalled for other reasons.
- Pairs with the RAM/peripheral Wishbone slaves on the bus.

Parameters:
- AW, 32, address width.
- DW, 32, data width; a multiple of 8.
- TIMEOUT_CYCLES, 16, cycles spent in BUSY before an abort; used only with WB_TIMEOUT_EN.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  asynchronous, active-low reset.
- stall_i  in  6  pipeline stall vector; nonzero means the pipeline is frozen.
- flush_i  in  1  pipeline flush; abandons any in-flight request.
- cpu_ce_i  in  1  CPU request valid, held high until the result is taken.
- cpu_addr_i  in  AW  request byte address.
- cpu_data_i  in  DW  write data.
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_sel_i  in  DW/8  byte lane select.
- cpu_data_o  out  DW  read data returned to the CPU.
- stallreq_o  out  1  stall request to the pipeline controller.
- wb_adr_o  out  AW  Wishbone address.
- wb_dat_o  out  DW  Wishbone write data.
- wb_dat_i  in  DW  Wishbone read data.
- wb_we_o  out  1  Wishbone write enable.
- wb_sel_o  out  DW/8  Wishbone byte select.
- wb_stb_o  out  1  Wishbone strobe.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_o  out  1  timeout abort flag; present only with WB_TIMEOUT_EN.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - All wb_* outputs, rd_buf and cpu_data_o = 0.
  - stallreq_o = 0.
- State machine: IDLE, BUSY, WAIT_STALL.
- IDLE:
  - If cpu_ce_i=1 and flush_i=0, register adr/dat/we/sel from the CPU, set cyc=stb=1 and go to BUSY on the next edge.
  - stallreq_o is asserted combinationally in the same cycle.
- BUSY:
  - Hold every wb_* output stable until the ack.
  - On wb_ack_i=1: drop cyc/stb/we and clear adr/dat/sel at the edge.
  - On a read ack, capture wb_dat_i into rd_buf.
  - Next state is WAIT_STALL if stall_i≠0, otherwise IDLE.
- WAIT_STALL:
  - cyc/stb stay 0.
  - Go to IDLE when stall_i==0.
- flush_i=1 in BUSY or WAIT_STALL:
  - Drop cyc/stb next edge and go to IDLE; no data is returned.
  - Flush takes priority over ack in the same cycle.
- stallreq_o (combinational):
  - IDLE: cpu_ce_i & ~flush_i.
  - BUSY: ~wb_ack_i.
  - WAIT_STALL: 0.
- cpu_data_o (combinational):
  - BUSY with ack on a read: wb_dat_i.
  - WAIT_STALL: rd_buf.
  - Otherwise: 0.
  - Writes return 0.
- Latency: a slave with a registered ack (ack one cycle after stb) gives a 2-cycle stall per access; a combinational-ack slave gives 1.
- wb_ack_i is ignored outside BUSY. This tolerates slaves whose registered ack lingers for one cycle after stb falls.
- Back-to-back requests: a new stb is issued no earlier than 2 cycles after the previous ack edge. This guarantees one stb-low cycle between accesses.
- cpu_* inputs that change while in BUSY are ignored; the latched request is used.
- Reset asserted mid-BUSY: the cycle is aborted immediately, with cyc/stb cleared asynchronously.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 with no ack: cyc/stb drop and wb_err_o pulses high for 1 cycle.
  - cpu_data_o = 0xFFFFFFFF for that one cycle, stallreq_o=0, then IDLE.
- Without the macro: no counter and no wb_err_o port; BUSY waits for ack indefinitely.

Decomposition:
- Shared defines package:
  - State encodings (IDLE=2'b00, BUSY=2'b01, WAIT_STALL=2'b10).
  - Stall vector width 6.
  - ZeroWord.
  - Bus width constants.
- Sub-module wb_timeout_cnt (counter plus terminal flag), instantiated only under WB_TIMEOUT_EN.

Test Plan:
- Read, slave acks 1 cycle after stb, wb_dat_i=0xDEADBEEF, stall_i=0:
  - stallreq_o high 2 cycles.
  - cpu_data_o=0xDEADBEEF in the ack cycle.
  - cyc/stb low the next cycle.
- Write addr=0x10, data=0x12345678, sel=4'b0011:
  - wb_adr_o/dat_o/sel_o/we_o=1 held until ack.
  - cpu_data_o=0.
  - IDLE after ack.
- Read acked while stall_i=6'b000011 held 3 more cycles:
  - WAIT_STALL entered.
  - cpu_data_o=rd_buf value for all 3 cycles.
  - stallreq_o=0.
  - IDLE when stall_i=0.
- flush_i pulse during BUSY with no ack: cyc/stb=0 next edge, IDLE, no data returned.
- Same-cycle flush_i and ack: flush wins and rd_buf is unchanged.
- Lingering ack after a completed read with cpu_ce_i still high: no spurious completion, and the second stb rises exactly 2 cycles after the first ack.
- WB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and no ack:
  - wb_err_o pulse on the 16th BUSY cycle.
  - cpu_data_o=0xFFFFFFFF for that cycle.
  - cyc low next.
